// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver
//   PS/2 keyboard receiver. Synchronises and de-glitches the PS/2 clock,
//   deserialises 11-bit frames (start, 8 data LSB first, odd parity, stop),
//   validates them and queues good scan codes in a small FIFO.
//
// Parameters
//   FILTER_LEN     : equal filtered samples needed to change the clock level (>=2)
//   FIFO_DEPTH     : scan-code FIFO entries (power of two, >=2)
//   TIMEOUT_CYCLES : clk cycles allowed between falling edges inside a frame
//   CHECK_PARITY   : 1 = reject frames with bad odd parity, 0 = ignore parity
//
// Ports
//   clk, reset_n   : system clock, asynchronous active-low reset
//   ps2c, ps2d     : raw PS/2 clock / data pins
//   rx_en          : allows a new frame to start
//   rd_en          : pop the FIFO head (ignored when empty)
//   dout           : FIFO head, 8'h00 when empty
//   empty, full    : FIFO status
//   count          : occupied FIFO entries
//   rx_done_tick   : pulse, good frame pushed
//   frame_err      : pulse, bad start or stop bit
//   parity_err     : pulse, odd-parity failure
//   overrun        : pulse, good frame dropped because the FIFO was full
//   timeout        : pulse, frame aborted by the watchdog
module ps2_frame_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CHECK_PARITY   = 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               ps2c,
    input  logic                               ps2d,
    input  logic                               rx_en,
    input  logic                               rd_en,
    output logic [7:0]                         dout,
    output logic                               empty,
    output logic                               full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
    output logic                               rx_done_tick,
    output logic                               frame_err,
    output logic                               parity_err,
    output logic                               overrun,
    output logic                               timeout
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RX,
        S_CHECK
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers and clock filter
    // ------------------------------------------------------------------
    logic                  c_s1, c_s2, d_s1, d_s2;
    logic [FILTER_LEN-1:0] filt;
    logic                  filt_lvl, filt_lvl_next;
    logic                  fall_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_s1     <= 1'b0;
            c_s2     <= 1'b0;
            d_s1     <= 1'b0;
            d_s2     <= 1'b0;
            filt     <= '0;
            filt_lvl <= 1'b0;
        end else begin
            c_s1     <= ps2c;
            c_s2     <= c_s1;
            d_s1     <= ps2d;
            d_s2     <= d_s1;
            filt     <= {c_s2, filt[FILTER_LEN-1:1]};
            filt_lvl <= filt_lvl_next;
        end
    end

    // Level only moves once the whole window agrees; mixed windows hold.
    always_comb begin
        filt_lvl_next = filt_lvl;
        if (filt == '1) begin
            filt_lvl_next = 1'b1;
        end else if (filt == '0) begin
            filt_lvl_next = 1'b0;
        end
    end

    assign fall_edge = filt_lvl & ~filt_lvl_next;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t          state, state_next;
    logic [10:0]     shreg, shreg_next;
    logic [3:0]      bit_cnt, bit_cnt_next;
    logic [WW-1:0]   wd, wd_next;
    logic            push;
    logic            bad_frame, bad_parity;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            wd      <= '0;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            wd      <= wd_next;
        end
    end

    assign bad_frame  = shreg[0] | ~shreg[10];
    assign bad_parity = (CHECK_PARITY != 0) && !(^shreg[9:1]);

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        wd_next      = wd;
        push         = 1'b0;
        rx_done_tick = 1'b0;
        frame_err    = 1'b0;
        parity_err   = 1'b0;
        overrun      = 1'b0;
        timeout      = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall_edge && rx_en) begin
                    shreg_next   = {d_s2, shreg[10:1]};
                    bit_cnt_next = 4'd10;
                    wd_next      = '0;
                    state_next   = S_RX;
                end
            end
            S_RX: begin
                if (fall_edge) begin
                    shreg_next   = {d_s2, shreg[10:1]};
                    bit_cnt_next = bit_cnt - 4'd1;
                    wd_next      = '0;
                    // Counter still reads 1 on the edge carrying the stop bit.
                    if (bit_cnt == 4'd1) begin
                        state_next = S_CHECK;
                    end
                end else if (wd == WW'(TIMEOUT_CYCLES - 1)) begin
                    timeout      = 1'b1;
                    shreg_next   = '0;
                    bit_cnt_next = '0;
                    wd_next      = '0;
                    state_next   = S_IDLE;
                end else begin
                    wd_next = wd + 1'b1;
                end
            end
            S_CHECK: begin
                frame_err  = bad_frame;
                parity_err = bad_parity;
                if (!bad_frame && !bad_parity) begin
                    // A pop in this same cycle frees the slot we need.
                    if (!full || rd_en) begin
                        push         = 1'b1;
                        rx_done_tick = 1'b1;
                    end else begin
                        overrun = 1'b1;
                    end
                end
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scan-code FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_reg;
    logic          pop;

    assign pop   = rd_en && !empty;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(FIFO_DEPTH));
    assign count = count_reg;
    assign dout  = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shreg[8:1];
        end
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench: stimulus tasks push expected events / pop data into
// queues, a negedge monitor pops and compares whenever the DUTs present
// a pulse or a pop. Two DUTs share the pins: one checks parity, one not.
module tb_ps2_frame_receiver;

    localparam int FL    = 8;
    localparam int DEPTH = 4;
    localparam int TO    = 300;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       rx_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       rd_en_np = 1'b0;

    logic [7:0] dout, dout_np;
    logic       empty, full, empty_np, full_np;
    logic [2:0] count, count_np;
    logic       rx_done_tick, frame_err, parity_err, overrun, timeout;
    logic       rx_done_np, frame_err_np, parity_err_np, overrun_np, timeout_np;

    ps2_frame_receiver #(
        .FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CHECK_PARITY(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
        .rd_en(rd_en), .dout(dout), .empty(empty), .full(full), .count(count),
        .rx_done_tick(rx_done_tick), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun), .timeout(timeout)
    );

    ps2_frame_receiver #(
        .FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO), .CHECK_PARITY(0)
    ) dut_np (
        .clk(clk), .reset_n(reset_n), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
        .rd_en(rd_en_np), .dout(dout_np), .empty(empty_np), .full(full_np), .count(count_np),
        .rx_done_tick(rx_done_np), .frame_err(frame_err_np), .parity_err(parity_err_np),
        .overrun(overrun_np), .timeout(timeout_np)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO contents and expected observations.
    logic [7:0] model[$], model_np[$];
    logic [7:0] exp_pop[$], exp_pop_np[$];
    logic [4:0] exp_ev[$], exp_ev_np[$];   // {done, frame, parity, overrun, timeout}
    int         exp_to_cycle = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [4:0] ev, ev_np;
        ev    = {rx_done_tick, frame_err, parity_err, overrun, timeout};
        ev_np = {rx_done_np, frame_err_np, parity_err_np, overrun_np, timeout_np};
        if (!reset_n) begin
            if (ev != 5'd0 || ev_np != 5'd0) chk("pulse_in_reset", {ev, ev_np}, 0);
        end else begin
            if (ev != 5'd0) begin
                if (exp_ev.size() == 0) chk("unexpected_event", ev, 0);
                else begin
                    chk("event", ev, exp_ev.pop_front());
                    if (ev[0]) chk("timeout_cycle", cyc, exp_to_cycle);
                end
            end
            if (ev_np != 5'd0) begin
                if (exp_ev_np.size() == 0) chk("unexpected_event_np", ev_np, 0);
                else chk("event_np", ev_np, exp_ev_np.pop_front());
            end
            if (rd_en && !empty) begin
                if (exp_pop.size() == 0) chk("unexpected_pop", dout, 256);
                else chk("pop_data", dout, exp_pop.pop_front());
            end
            if (rd_en_np && !empty_np) begin
                if (exp_pop_np.size() == 0) chk("unexpected_pop_np", dout_np, 256);
                else chk("pop_data_np", dout_np, exp_pop_np.pop_front());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input bit bad_par,
                                       input bit bad_start, input bit bad_stop);
        return {~bad_stop, (~^d) ^ bad_par, d, bad_start};
    endfunction

    task automatic send_bits(input logic [10:0] b, input int nbits, input int hi, input int lo,
                             input bit glitch, input bit pop_check, input bit toggle_en,
                             output int last_fall);
        int c0;
        c0 = 0;
        for (int i = 0; i < nbits; i++) begin
            ps2d = b[i];
            if (toggle_en && i == 5) rx_en = 1'($urandom_range(0, 1));
            if (glitch) begin
                wait_cyc(FL + 6);
                ps2c = 1'b0;
                wait_cyc(FL - 1);
                ps2c = 1'b1;
            end
            wait_cyc(hi);
            ps2c = 1'b0;
            c0 = cyc;
            for (int j = 0; j < lo; j++) begin
                @(posedge clk);
                #1;
                // Stop-bit edge lands FL+2 cycles after the pin; CHECK is one later.
                if (pop_check && i == 10) rd_en = (cyc == c0 + 3 + FL);
            end
            rd_en = 1'b0;
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        last_fall = c0;
    endtask

    task automatic pop_main();
        rd_en = 1'b1;
        if (model.size() > 0) exp_pop.push_back(model.pop_front());
        wait_cyc(1);
        rd_en = 1'b0;
    endtask

    task automatic check_state();
        chk("count", count, model.size());
        chk("empty", empty, model.size() == 0);
        chk("full", full, model.size() == DEPTH);
        chk("dout", dout, (model.size() > 0) ? model[0] : 8'h00);
        chk("count_np", count_np, model_np.size());
    endtask

    task automatic do_frame(input logic [7:0] d, input bit bad_par, input bit bad_start,
                            input bit bad_stop, input bit en, input int hi, input int lo,
                            input bit glitch, input bit pop_check);
        logic [10:0] b;
        bit fe, pok, good, space;
        int lf;
        b = mk(d, bad_par, bad_start, bad_stop);
        rx_en = en;
        if (en) begin
            fe    = (b[0] != 1'b0) || (b[10] != 1'b1);
            pok   = (^b[9:1]) == 1'b1;
            good  = !fe && pok;
            space = (model.size() < DEPTH) || pop_check;
            if (pop_check) exp_pop.push_back(model.pop_front());
            exp_ev.push_back({good && space, fe, !pok, good && !space, 1'b0});
            if (good && space) model.push_back(d);
            exp_ev_np.push_back({!fe, fe, 1'b0, 1'b0, 1'b0});
            if (!fe) model_np.push_back(d);
        end
        send_bits(b, 11, hi, lo, glitch, pop_check && en, en, lf);
        rx_en = 1'b1;
        wait_cyc(FL + 10);
        if (model_np.size() > 0) begin
            rd_en_np = 1'b1;
            exp_pop_np.push_back(model_np.pop_front());
            wait_cyc(1);
            rd_en_np = 1'b0;
        end
        wait_cyc(2);
        check_state();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lf;
        logic [10:0] pb;
        wait_cyc(3);
        check_state();
        reset_n = 1'b1;
        rx_en = 1'b1;
        wait_cyc(FL + 10);
        check_state();

        // Good frame, then pop, then pop on empty.
        do_frame(8'h1C, 0, 0, 0, 1, 20, 20, 0, 0);
        pop_main();
        wait_cyc(2);
        check_state();
        pop_main();
        wait_cyc(2);
        check_state();

        // Parity error (accepted by the parity-blind DUT), stop-bit error.
        do_frame(8'h1C, 1, 0, 0, 1, 20, 20, 0, 0);
        do_frame(8'hF0, 0, 0, 1, 1, 20, 20, 0, 0);
        do_frame(8'h33, 0, 1, 0, 1, 20, 20, 0, 0);
        while (model.size() > 0) pop_main();

        // Overrun, then simultaneous pop in the CHECK cycle.
        for (int k = 1; k <= 5; k++) do_frame(8'(k), 0, 0, 0, 1, 20, 20, 0, 0);
        pop_main();
        do_frame(8'h05, 0, 0, 0, 1, 20, 20, 0, 0);
        do_frame(8'h06, 0, 0, 0, 1, 20, 20, 0, 1);
        while (model.size() > 0) pop_main();
        wait_cyc(2);
        check_state();

        // Watchdog: 5 edges then silence.
        pb = mk(8'h5A, 0, 0, 0);
        send_bits(pb, 5, 20, 20, 0, 0, 0, lf);
        exp_to_cycle = lf + 2 + FL + TO;
        exp_ev.push_back(5'b00001);
        exp_ev_np.push_back(5'b00001);
        wait_cyc(TO + FL + 40);
        do_frame(8'hF0, 0, 0, 0, 1, 20, 20, 0, 0);

        // Glitches shorter than the filter; lows of FL+3 cycles still register.
        do_frame(8'h1C, 0, 0, 0, 1, 20, 20, 1, 0);
        do_frame(8'hA7, 0, 0, 0, 1, 20, FL + 3, 0, 0);

        // Frame ignored while rx_en is low.
        do_frame(8'h77, 0, 0, 0, 0, 20, 20, 0, 0);

        // Reset mid-frame with two entries queued.
        while (model.size() > 0) pop_main();
        do_frame(8'h11, 0, 0, 0, 1, 20, 20, 0, 0);
        do_frame(8'h22, 0, 0, 0, 1, 20, 20, 0, 0);
        send_bits(mk(8'h99, 0, 0, 0), 6, 20, 20, 0, 0, 0, lf);
        wait_cyc(3);
        reset_n = 1'b0;
        model.delete();
        model_np.delete();
        wait_cyc(3);
        chk("count_in_reset", count, 0);
        chk("empty_in_reset", empty, 1);
        chk("dout_in_reset", dout, 0);
        reset_n = 1'b1;
        wait_cyc(FL + 10);
        check_state();
        do_frame(8'h2A, 0, 0, 0, 1, 20, 20, 0, 0);

        // Randomised traffic.
        for (int n = 0; n < 24; n++) begin
            int r;
            bit pc;
            r  = $urandom_range(0, 9);
            pc = (model.size() > 0) && (r >= 3) && ($urandom_range(0, 3) == 0);
            do_frame(8'($urandom), r == 0, (r == 1) && $urandom_range(0, 1) == 1,
                     (r == 1), r != 2, $urandom_range(15, 25), $urandom_range(FL + 3, 25),
                     $urandom_range(0, 4) == 0, pc && r != 2);
            if (model.size() > 0 && $urandom_range(0, 1) == 1) pop_main();
        end
        while (model.size() > 0) pop_main();
        wait_cyc(5);
        check_state();

        chk("leftover_events", exp_ev.size() + exp_ev_np.size(), 0);
        chk("leftover_pops", exp_pop.size() + exp_pop_np.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
